// File: rtl/ramrw_arb_pkg.sv
// Shared types and helpers for ramrw_arb: round-robin grant search,
// pointer advance and the fixed read latency.
package ramrw_arb_pkg;

   localparam int RDLAT  = 3;
   localparam int MAXREQ = 8;

   // Scan from ptr upward with wrap; the first asserted request wins.
   function automatic logic [MAXREQ-1:0] rr_grant(input logic [MAXREQ-1:0] req,
                                                  input logic [2:0]        ptr,
                                                  input int                nreq);
      logic [MAXREQ-1:0] gnt;
      logic [2:0]        sel;
      int                idx;
      gnt = '0;
      for (int i = 0; i < MAXREQ; i++) begin
         if (i < nreq) begin
            idx = int'(ptr) + i;
            if (idx >= nreq) idx = idx - nreq;
            sel = idx[2:0];
            if (gnt == '0 && req[sel]) gnt[sel] = 1'b1;
         end
      end
      return gnt;
   endfunction

   function automatic logic [2:0] rr_next(input logic [MAXREQ-1:0] gnt,
                                          input logic [2:0]        ptr,
                                          input int                nreq);
      logic [2:0] nxt;
      nxt = ptr;
      for (int i = 0; i < MAXREQ; i++) begin
         if (gnt[i]) nxt = (i == nreq - 1) ? 3'd0 : 3'(i + 1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/ramrw_arb_if.sv
// Client and RAM-side signal bundle for ramrw_arb.
// Handshake: wreq/rreq are levels held by the client until the matching
// one-hot wgnt/rgnt bit is seen in the same cycle; rvld qualifies rdata.
interface ramrw_arb_if #(
   parameter int NREQ    = 4,
   parameter int ADDRBIT = 9,
   parameter int WIDTH   = 32
);
   logic [NREQ-1:0]         wreq;
   logic [NREQ*ADDRBIT-1:0] wa;
   logic [NREQ*WIDTH-1:0]   wd;
   logic [NREQ-1:0]         wgnt;
   logic [NREQ-1:0]         rreq;
   logic [NREQ*ADDRBIT-1:0] ra;
   logic [NREQ-1:0]         rgnt;
   logic [NREQ-1:0]         rvld;
   logic [WIDTH-1:0]        rdata;
   logic                    ram_we;
   logic [ADDRBIT-1:0]      ram_wa;
   logic [WIDTH-1:0]        ram_di;
   logic [ADDRBIT-1:0]      ram_ra;
   logic [WIDTH-1:0]        ram_do;

   modport slave (
      input  wreq, wa, wd, rreq, ra, ram_do,
      output wgnt, rgnt, rvld, rdata, ram_we, ram_wa, ram_di, ram_ra
   );

   modport master (
      output wreq, wa, wd, rreq, ra, ram_do,
      input  wgnt, rgnt, rvld, rdata, ram_we, ram_wa, ram_di, ram_ra
   );
endinterface

// File: rtl/ramrw_arb_rr_arb.sv
// Combinational round-robin arbiter: request vector + pointer in,
// one-hot grant + next pointer out (pointer holds when nothing is granted).
import ramrw_arb_pkg::*;

module rr_arb #(
   parameter int NREQ   = 4,
   parameter int PTRBIT = 2
) (
   input  logic [NREQ-1:0]   req_i,
   input  logic [PTRBIT-1:0] ptr_i,
   output logic [NREQ-1:0]   gnt_o,
   output logic [PTRBIT-1:0] ptr_nxt_o
);
   assign gnt_o     = NREQ'(rr_grant(MAXREQ'(req_i), 3'(ptr_i), NREQ));
   assign ptr_nxt_o = PTRBIT'(rr_next(MAXREQ'(gnt_o), 3'(ptr_i), NREQ));
endmodule

// File: rtl/ramrw_arb.sv
// Round-robin sharing of one write port and one registered read port of a RAM.
// Define RAMRW_ARB_RAWBYPASS_EN to forward same-edge write data to the read.
import ramrw_arb_pkg::*;

module ramrw_arb #(
   parameter int NREQ    = 4,
   parameter int ADDRBIT = 9,
   parameter int WIDTH   = 32,
   parameter int PTRBIT  = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   ramrw_arb_if.slave    bus
);
   logic [PTRBIT-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [NREQ-1:0]    wgnt_raw, rgnt_raw, wgnt, rgnt;
   logic [ADDRBIT-1:0] wa_sel, ra_sel;
   logic [WIDTH-1:0]   wd_sel;

   logic               ram_we_q, ram_we_d;
   logic [ADDRBIT-1:0] ram_wa_q, ram_wa_d, ram_ra_q, ram_ra_d;
   logic [WIDTH-1:0]   ram_di_q, ram_di_d;
   logic [NREQ-1:0]    tag1_q, tag2_q, rvld_q;
   logic [WIDTH-1:0]   rdata_q, rdata_d;

   rr_arb #(.NREQ(NREQ), .PTRBIT(PTRBIT)) u_warb (
      .req_i(bus.wreq), .ptr_i(wptr_q), .gnt_o(wgnt_raw), .ptr_nxt_o(wptr_d)
   );
   rr_arb #(.NREQ(NREQ), .PTRBIT(PTRBIT)) u_rarb (
      .req_i(bus.rreq), .ptr_i(rptr_q), .gnt_o(rgnt_raw), .ptr_nxt_o(rptr_d)
   );

   // Grants are suppressed while reset is asserted.
   assign wgnt     = rst_n ? wgnt_raw : '0;
   assign rgnt     = rst_n ? rgnt_raw : '0;
   assign bus.wgnt = wgnt;
   assign bus.rgnt = rgnt;

   always_comb begin
      wa_sel = '0;
      wd_sel = '0;
      ra_sel = '0;
      for (int k = 0; k < NREQ; k++) begin
         wa_sel = wa_sel | (bus.wa[k*ADDRBIT +: ADDRBIT] & {ADDRBIT{wgnt[k]}});
         wd_sel = wd_sel | (bus.wd[k*WIDTH +: WIDTH] & {WIDTH{wgnt[k]}});
         ra_sel = ra_sel | (bus.ra[k*ADDRBIT +: ADDRBIT] & {ADDRBIT{rgnt[k]}});
      end
   end

`ifdef RAMRW_ARB_RAWBYPASS_EN
   logic             hit_q;
   logic [WIDTH-1:0] byp_q;

   // Captured on the edge where the RAM samples ram_ra, aligned with tag2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_q <= 1'b0;
         byp_q <= '0;
      end else begin
         hit_q <= ram_we_q && (ram_wa_q == ram_ra_q);
         byp_q <= ram_di_q;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (|tag2_q) rdata_d = hit_q ? byp_q : bus.ram_do;
   end
`else
   always_comb begin
      rdata_d = rdata_q;
      if (|tag2_q) rdata_d = bus.ram_do;
   end
`endif

   always_comb begin
      ram_we_d = |wgnt;
      ram_wa_d = (|wgnt) ? wa_sel : ram_wa_q;
      ram_di_d = (|wgnt) ? wd_sel : ram_di_q;
      ram_ra_d = (|rgnt) ? ra_sel : ram_ra_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         ram_we_q <= 1'b0;
         ram_wa_q <= '0;
         ram_di_q <= '0;
         ram_ra_q <= '0;
         tag1_q   <= '0;
         tag2_q   <= '0;
         rvld_q   <= '0;
         rdata_q  <= '0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         ram_we_q <= ram_we_d;
         ram_wa_q <= ram_wa_d;
         ram_di_q <= ram_di_d;
         ram_ra_q <= ram_ra_d;
         tag1_q   <= rgnt;
         tag2_q   <= tag1_q;
         rvld_q   <= tag2_q;
         rdata_q  <= rdata_d;
      end
   end

   assign bus.ram_we = ram_we_q;
   assign bus.ram_wa = ram_wa_q;
   assign bus.ram_di = ram_di_q;
   assign bus.ram_ra = ram_ra_q;
   assign bus.rvld   = rvld_q;
   assign bus.rdata  = rdata_q;
endmodule
